// File: rtl/uart_pkg.sv
// UART receiver shared types and constants.
// Oversampling geometry and the bit-vote helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  localparam int         OSR      = 16;
  localparam logic [3:0] SAMP_LO  = 4'd7;
  localparam logic [3:0] SAMP_MID = 4'd8;
  localparam logic [3:0] SAMP_HI  = 4'd9;
  localparam logic [3:0] TCNT_END = 4'(OSR - 1);

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/os_tick_gen.sv
// Oversample tick generator.
// One-clk tick every TICK_DIV clks; parked at zero while disabled.
module os_tick_gen #(
  parameter int TICK_DIV = 54
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Tick on the last count; restart on tick or when disabled.
  always_comb begin
    tick  = en & (cnt_q == LAST);
    cnt_d = cnt_q + CW'(1);
    if (!en || tick) begin
      cnt_d = '0;
    end
  end

  // Divider counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// 16x oversampled 8N1 UART receiver with majority vote.
// Holds one byte for a valid/ready consumer; flags framing and overrun.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int TICK_DIV = 54
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] d_rx,
  output logic       vld_rx,
  input  logic       rdy_rx,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  logic       sync1_q;
  logic       rxs_q;
  logic       rxs_d_q;
  state_e     state_q, state_d;
  logic [3:0] tcnt_q, tcnt_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic       s7_q, s7_d;
  logic       s8_q, s8_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] dat_q, dat_d;
  logic       vld_q, vld_d;
  logic       fe_q, fe_d;
  logic       ov_q, ov_d;

  logic tick;
  logic fall;
  logic bitv;
  logic at_dec;
  logic at_wrap;
  logic complete;

  os_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (state_q != IDLE),
    .tick(tick)
  );

  assign fall    = rxs_d_q & ~rxs_q;
  assign bitv    = maj3(s7_q, s8_q, rxs_q);
  assign at_dec  = tick & (tcnt_q == SAMP_HI);
  assign at_wrap = tick & (tcnt_q == TCNT_END);

  // Frame FSM: bit timing, sampling, shifting and stop decision.
  always_comb begin
    state_d  = state_q;
    tcnt_d   = tick ? tcnt_q + 4'd1 : tcnt_q;
    bcnt_d   = bcnt_q;
    s7_d     = s7_q;
    s8_d     = s8_q;
    sh_d     = sh_q;
    complete = 1'b0;
    fe_d     = 1'b0;
    if (tick && tcnt_q == SAMP_LO) begin
      s7_d = rxs_q;
    end
    if (tick && tcnt_q == SAMP_MID) begin
      s8_d = rxs_q;
    end
    unique case (state_q)
      IDLE: begin
        tcnt_d = '0;
        if (fall) begin
          state_d = START;
        end
      end
      START: begin
        if (at_dec && bitv) begin
          state_d = IDLE;
        end else if (at_wrap) begin
          state_d = DATA;
          bcnt_d  = '0;
        end
      end
      DATA: begin
        if (at_dec) begin
          sh_d = {bitv, sh_q[7:1]};
        end
        if (at_wrap) begin
          if (bcnt_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bcnt_d = bcnt_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (at_dec) begin
          state_d  = IDLE;
          complete = bitv;
          fe_d     = ~bitv;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Hold register and consumer handshake.
  always_comb begin
    dat_d = dat_q;
    vld_d = vld_q;
    ov_d  = 1'b0;
    if (complete) begin
      if (!vld_q || rdy_rx) begin
        dat_d = sh_q;
        vld_d = 1'b1;
      end else begin
        ov_d = 1'b1;
      end
    end else if (vld_q && rdy_rx) begin
      vld_d = 1'b0;
    end
  end

  // State, datapath and synchronizer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
      rxs_d_q <= 1'b1;
      state_q <= IDLE;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      s7_q    <= 1'b1;
      s8_q    <= 1'b1;
      sh_q    <= '0;
      dat_q   <= '0;
      vld_q   <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      sync1_q <= rxd;
      rxs_q   <= sync1_q;
      rxs_d_q <= rxs_q;
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      s7_q    <= s7_d;
      s8_q    <= s8_d;
      sh_q    <= sh_d;
      dat_q   <= dat_d;
      vld_q   <= vld_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  assign d_rx      = dat_q;
  assign vld_rx    = vld_q;
  assign frame_err = fe_q;
  assign overrun   = ov_q;
  assign busy      = (state_q != IDLE);

endmodule
